// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   BYTE_W       width of one serial byte
//   asm_state_t  command-assembler states
//   rx_state_t   byte-receiver states
package uart_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE,
    ASSEMBLE
  } asm_state_t;

  typedef enum logic {
    RX_IDLE,
    RX_RECV
  } rx_state_t;

endpackage

// File: rtl/uart_cmd_assembler_rcv.sv
// UART_rcv: 8N1 serial byte receiver, LSB first.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   RX           serial line, idle high
//   rdy          a received byte is waiting in rx_data
//   rx_data      last received byte
//   clr_rdy      consumer acknowledge, clears rdy
// Parameter BAUD_CLKS is the bit period in clk cycles.
module UART_rcv
  import uart_pkg::*;
#(
  parameter int BAUD_CLKS = 2604
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  output logic              rdy,
  output logic [BYTE_W-1:0] rx_data,
  input  logic              clr_rdy
);

  localparam int BAUD_W = $clog2(BAUD_CLKS);
  localparam logic [BAUD_W-1:0] HALF_BIT = BAUD_W'(BAUD_CLKS / 2 - 1);
  localparam logic [BAUD_W-1:0] FULL_BIT = BAUD_W'(BAUD_CLKS - 1);

  rx_state_t         state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [7:0]        shft_q, shft_d;
  logic              rdy_q, rdy_d;
  logic              rx_meta_q, rx_s_q;

  // Two-stage synchronizer; line idles high so reset to 1 to avoid a false start.
  // NOTE: sequential state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
    end
  end

  // bit_q counts samples: 0 = start bit, 1..8 = data, 9 = stop bit.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shft_d  = shft_q;
    rdy_d   = rdy_q & ~clr_rdy;

    case (state_q)
      RX_IDLE: begin
        if (!rx_s_q) begin
          // First sample lands mid start bit, later ones a full bit apart.
          state_d = RX_RECV;
          baud_d  = HALF_BIT;
          bit_d   = 4'd0;
          rdy_d   = 1'b0;
        end
      end
      RX_RECV: begin
        if (baud_q != '0) begin
          baud_d = baud_q - 1'b1;
        end else begin
          baud_d = FULL_BIT;
          bit_d  = bit_q + 1'b1;
          if (bit_q == 4'd0) begin
            // Start bit went high again: glitch, not a frame.
            if (rx_s_q) state_d = RX_IDLE;
          end else if (bit_q <= 4'd8) begin
            shft_d = {rx_s_q, shft_q[7:1]};
          end else begin
            // Stop bit: only a correctly framed byte is reported.
            state_d = RX_IDLE;
            rdy_d   = rx_s_q;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shft_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shft_q  <= shft_d;
      rdy_q   <= rdy_d;
    end
  end

  assign rdy     = rdy_q;
  assign rx_data = shft_q;

endmodule

// File: rtl/uart_cmd_assembler.sv
// uart_cmd_assembler: packs NUM_BYTES consecutive UART bytes into one command word.
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   RX            serial receive line
//   clr_cmd_rdy   consumer acknowledge; clears cmd_rdy and ovr
//   cmd           last completed command
//   cmd_rdy       cmd holds an unconsumed command
//   ovr           sticky: a completed command was dropped while cmd_rdy was high
//   timeout       one-cycle pulse: a partial command was discarded
// Parameters:
//   NUM_BYTES     bytes per command, 2..8
//   TIMEOUT_CLKS  idle clocks allowed between bytes of one command
//   MSB_FIRST     1: first byte lands in the top byte; 0: first byte lands in cmd[7:0]
//   BAUD_CLKS     serial bit period in clk cycles
module uart_cmd_assembler
  import uart_pkg::*;
#(
  parameter int NUM_BYTES    = 2,
  parameter int TIMEOUT_CLKS = 50000,
  parameter int MSB_FIRST    = 1,
  parameter int BAUD_CLKS    = 2604
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        RX,
  input  logic                        clr_cmd_rdy,
  output logic [NUM_BYTES*BYTE_W-1:0] cmd,
  output logic                        cmd_rdy,
  output logic                        ovr,
  output logic                        timeout
);

  localparam int CMD_W = NUM_BYTES * BYTE_W;
  localparam int CNT_W = $clog2(NUM_BYTES);
  localparam int TMR_W = $clog2(TIMEOUT_CLKS);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT_CLKS - 1);

  logic              rx_rdy;
  logic [BYTE_W-1:0] rx_data;
  logic              clr_rdy;

  asm_state_t        state_q, state_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CMD_W-1:0]  shift_q, shift_d;
  logic [CMD_W-1:0]  shift_in;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              cmd_rdy_q, cmd_rdy_d;
  logic              ovr_q, ovr_d;
  logic              timeout_q, timeout_d;
  logic              complete;

  UART_rcv #(
    .BAUD_CLKS(BAUD_CLKS)
  ) u_rcv (
    .clk    (clk),
    .rst_n  (rst_n),
    .RX     (RX),
    .rdy    (rx_rdy),
    .rx_data(rx_data),
    .clr_rdy(clr_rdy)
  );

  // Every byte is taken the cycle it appears, so rdy is acknowledged at once.
  assign clr_rdy = rx_rdy;

  // Shift register with the incoming byte already inserted; after NUM_BYTES
  // insertions the oldest bytes have been pushed out, so no clear is needed.
  always_comb begin
    if (MSB_FIRST != 0) shift_in = {shift_q[CMD_W-BYTE_W-1:0], rx_data};
    else                shift_in = {rx_data, shift_q[CMD_W-1:BYTE_W]};
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    tmr_d      = tmr_q;
    shift_d    = shift_q;
    timeout_d  = 1'b0;
    complete   = 1'b0;

    case (state_q)
      IDLE: begin
        if (rx_rdy) begin
          shift_d    = shift_in;
          byte_cnt_d = CNT_W'(1);
          tmr_d      = '0;
          state_d    = ASSEMBLE;
        end
      end
      ASSEMBLE: begin
        // A byte arriving in the expiry cycle wins over the timeout.
        if (rx_rdy) begin
          shift_d = shift_in;
          tmr_d   = '0;
          if (byte_cnt_q == LAST_BYTE) begin
            complete   = 1'b1;
            byte_cnt_d = '0;
            state_d    = IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end else if (tmr_q == TMR_LAST) begin
          shift_d    = '0;
          byte_cnt_d = '0;
          tmr_d      = '0;
          timeout_d  = 1'b1;
          state_d    = IDLE;
        end else if (tmr_q != '1) begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output flags. An acknowledge in the completion cycle frees the slot, so
  // the new word loads and the overrun flag is cleared instead of set.
  always_comb begin
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    ovr_d     = ovr_q;

    if (complete) begin
      if (!cmd_rdy_q || clr_cmd_rdy) begin
        cmd_d     = shift_in;
        cmd_rdy_d = 1'b1;
        if (clr_cmd_rdy) ovr_d = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
      ovr_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      tmr_q      <= '0;
      shift_q    <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      ovr_q      <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      tmr_q      <= tmr_d;
      shift_q    <= shift_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
      ovr_q      <= ovr_d;
      timeout_q  <= timeout_d;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign ovr     = ovr_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler: a 2-byte MSB-first instance and a
// 4-byte LSB-first instance, driven by directed serial frames. Expected command
// words are queued when their final byte is sent and popped when checked.
module tb_uart_cmd_assembler;

  localparam int BIT  = 16;
  localparam int TOUT = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        rx4 = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        clr4 = 1'b0;
  logic [15:0] cmd;
  logic        cmd_rdy, ovr, timeout;
  logic [31:0] cmd4;
  logic        cmd_rdy4, ovr4, timeout4;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  uart_cmd_assembler #(
    .NUM_BYTES(2), .TIMEOUT_CLKS(TOUT), .MSB_FIRST(1), .BAUD_CLKS(BIT)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .RX(rx), .clr_cmd_rdy(clr_cmd_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .ovr(ovr), .timeout(timeout)
  );

  uart_cmd_assembler #(
    .NUM_BYTES(4), .TIMEOUT_CLKS(TOUT), .MSB_FIRST(0), .BAUD_CLKS(BIT)
  ) u_dut4 (
    .clk(clk), .rst_n(rst_n), .RX(rx4), .clr_cmd_rdy(clr4),
    .cmd(cmd4), .cmd_rdy(cmd_rdy4), .ovr(ovr4), .timeout(timeout4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic drive_line(input int which, input logic v);
    if (which == 0) rx = v;
    else            rx4 = v;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
  endtask

  // mode 0: plain frame.
  // mode 1: check cmd_rdy rises exactly one cycle after the receiver's rdy.
  // mode 2: assert clr_cmd_rdy in the rdy cycle (completion cycle).
  task automatic send_byte(input int which, input logic [7:0] b, input int mode, input string tag);
    logic found;
    @(negedge clk);
    drive_line(which, 1'b0);
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      drive_line(which, b[i]);
      repeat (BIT) @(negedge clk);
    end
    drive_line(which, 1'b1);
    if (mode == 0) begin
      repeat (BIT) @(negedge clk);
    end else begin
      found = 1'b0;
      for (int n = 0; n < 2 * BIT && !found; n++) begin
        @(negedge clk);
        if (u_dut.rx_rdy) found = 1'b1;
      end
      check({tag, "_rdy_seen"}, 32'(found), 32'd1);
      if (found) begin
        if (mode == 1) begin
          check({tag, "_cmd_rdy_in_rdy_cycle"}, 32'(cmd_rdy), 32'd0);
          @(negedge clk);
          check({tag, "_cmd_rdy_next_cycle"}, 32'(cmd_rdy), 32'd1);
          check({tag, "_cmd"}, 32'(cmd), pop_exp());
        end else begin
          clr_cmd_rdy = 1'b1;
          @(negedge clk);
          clr_cmd_rdy = 1'b0;
        end
      end
      repeat (BIT) @(negedge clk);
    end
  endtask

  initial begin
    int pulses;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cmd", 32'(cmd), 32'h0);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_ovr", 32'(ovr), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_cmd4", cmd4, 32'h0);
    check("rst_flags4", {29'd0, cmd_rdy4, ovr4, timeout4}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: basic pair, latency, acknowledge
    send_byte(0, 8'hA5, 0, "t1_b0");
    exp_q.push_back(32'hA53C);
    send_byte(0, 8'h3C, 1, "t1");
    pulse_clr();
    check("t1_cleared_rdy", 32'(cmd_rdy), 32'd0);
    check("t1_cmd_held", 32'(cmd), 32'hA53C);

    // 2: 4-byte, LSB-first instance
    send_byte(1, 8'h11, 0, "t2_b0");
    send_byte(1, 8'h22, 0, "t2_b1");
    send_byte(1, 8'h33, 0, "t2_b2");
    exp_q.push_back(32'h44332211);
    send_byte(1, 8'h44, 0, "t2_b3");
    check("t2_cmd_rdy4", 32'(cmd_rdy4), 32'd1);
    check("t2_cmd4", cmd4, pop_exp());

    // 3: timeout on a partial command, then resync
    send_byte(0, 8'hDE, 0, "t3_b0");
    pulses = 0;
    repeat (TOUT + 100) begin
      @(negedge clk);
      if (timeout) pulses++;
    end
    check("t3_timeout_pulses", 32'(pulses), 32'd1);
    check("t3_cmd_rdy_untouched", 32'(cmd_rdy), 32'd0);
    check("t3_cmd_untouched", 32'(cmd), 32'hA53C);
    send_byte(0, 8'h12, 0, "t3_b1");
    exp_q.push_back(32'h1234);
    send_byte(0, 8'h34, 0, "t3_b2");
    check("t3_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("t3_cmd", 32'(cmd), pop_exp());
    pulse_clr();

    // 4: overrun
    send_byte(0, 8'h11, 0, "t4_b0");
    exp_q.push_back(32'h1111);
    send_byte(0, 8'h11, 0, "t4_b1");
    check("t4_first_cmd", 32'(cmd), pop_exp());
    send_byte(0, 8'h22, 0, "t4_b2");
    send_byte(0, 8'h22, 0, "t4_b3");
    check("t4_cmd_held", 32'(cmd), 32'h1111);
    check("t4_ovr_set", 32'(ovr), 32'd1);
    check("t4_cmd_rdy_still", 32'(cmd_rdy), 32'd1);
    pulse_clr();
    check("t4_ovr_cleared", 32'(ovr), 32'd0);
    check("t4_cmd_rdy_cleared", 32'(cmd_rdy), 32'd0);

    // 5: acknowledge coinciding with completion, while ovr is set
    send_byte(0, 8'h0F, 0, "t5_b0");
    exp_q.push_back(32'h0FF0);
    send_byte(0, 8'hF0, 0, "t5_b1");
    check("t5_pre_cmd", 32'(cmd), pop_exp());
    send_byte(0, 8'h99, 0, "t5_b2");
    send_byte(0, 8'h99, 0, "t5_b3");
    check("t5_pre_ovr", 32'(ovr), 32'd1);
    send_byte(0, 8'hBE, 0, "t5_b4");
    exp_q.push_back(32'hBEEF);
    send_byte(0, 8'hEF, 2, "t5");
    check("t5_cmd", 32'(cmd), pop_exp());
    check("t5_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("t5_ovr", 32'(ovr), 32'd0);

    // 6: reset in the middle of a command
    send_byte(0, 8'h77, 0, "t6_b0");
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_rst_cmd", 32'(cmd), 32'h0);
    check("t6_rst_flags", {29'd0, cmd_rdy, ovr, timeout}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(0, 8'h55, 0, "t6_b1");
    exp_q.push_back(32'h55AA);
    send_byte(0, 8'hAA, 0, "t6_b2");
    check("t6_cmd_rdy", 32'(cmd_rdy), 32'd1);
    check("t6_cmd", 32'(cmd), pop_exp());

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
